// File: rtl/param_frame_loader_if.sv
// Parameter-frame loader bus: stream input, parameter-bank write port and
// status flags, with debug visibility of the loader FSM state.
// Handshake: a stream byte transfers on a rising edge where data_valid and
// data_ready are both 1; data_ready depends only on loader state, never on
// data_valid, and a byte presented while data_ready is 0 is simply lost.
interface param_frame_loader_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_ready;
   logic              wr_en;
   logic [4:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              done;
   logic              checksum_err;
   logic [2:0]        dbg_state;

   modport master (
      output start, data_in, data_valid,
      input  data_ready, wr_en, wr_addr, wr_data, busy, done, checksum_err,
             dbg_state
   );

   modport slave (
      input  start, data_in, data_valid,
      output data_ready, wr_en, wr_addr, wr_data, busy, done, checksum_err,
             dbg_state
   );
endinterface

// File: rtl/param_frame_loader.sv
// Framed parameter loader: header byte, 24 parameter bytes, checksum byte.
// Parameter bytes become addressed single-byte writes (addr = neuron*6 + idx).
// The frame is good when the 8-bit sum of parameter and checksum bytes is 0.
// Optional macro PARAM_FRAME_LOADER_SHADOW_EN: parameter bytes are held in a
// shadow array and only flushed to the bank after a good checksum.
module param_frame_loader #(
   parameter int                DATA_W            = 8,
   parameter int                NUM_NEURONS       = 4,
   parameter int                PARAMS_PER_NEURON = 6,
   parameter logic [DATA_W-1:0] HEADER_BYTE       = 8'hA5
) (
   input logic                 clk,
   input logic                 reset,
   param_frame_loader_if.slave bus
);

   localparam int         NUM_SLOTS = NUM_NEURONS * PARAMS_PER_NEURON;
   localparam logic [4:0] LAST_SLOT = 5'(NUM_SLOTS - 1);
   localparam logic [4:0] END_SLOT  = 5'(NUM_SLOTS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_LOAD  = 3'd2,
      S_CHK   = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5,
      S_FLUSH = 3'd6
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        cnt;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] chk_sum;
   logic              ready;
   logic              accept;
   logic              arm;
   logic              busy_c;
   logic              wr_en_q;
   logic [4:0]        wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

`ifdef PARAM_FRAME_LOADER_SHADOW_EN
   logic [DATA_W-1:0] shadow [0:NUM_SLOTS-1];
`endif

   assign ready   = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
   assign accept  = bus.data_valid && ready;
   assign chk_sum = sum + bus.data_in;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; arm marks a (re)start that clears counter and sum.
   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      busy_c    = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               state_nxt = S_HDR;
               arm       = 1'b1;
            end
         end
         S_HDR: begin
            busy_c = 1'b1;
            if (accept && (bus.data_in == HEADER_BYTE)) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            busy_c = 1'b1;
            if (accept && (cnt == LAST_SLOT)) begin
               state_nxt = S_CHK;
            end
         end
         S_CHK: begin
            busy_c = 1'b1;
            if (accept) begin
               if (chk_sum == '0) begin
`ifdef PARAM_FRAME_LOADER_SHADOW_EN
                  state_nxt = S_FLUSH;
`else
                  state_nxt = S_DONE;
`endif
               end else begin
                  state_nxt = S_ERR;
               end
            end
         end
         S_FLUSH: begin
            busy_c = 1'b1;
            // One extra cycle after the last write so done follows it.
            if (cnt == END_SLOT) begin
               state_nxt = S_DONE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Counter, running checksum and registered write port.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         sum       <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (arm) begin
            cnt <= '0;
            sum <= '0;
         end else if ((state == S_LOAD) && accept) begin
            sum <= sum + bus.data_in;
            cnt <= cnt + 5'd1;
`ifndef PARAM_FRAME_LOADER_SHADOW_EN
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt;
            wr_data_q <= bus.data_in;
`endif
         end
`ifdef PARAM_FRAME_LOADER_SHADOW_EN
         else if ((state == S_CHK) && accept) begin
            cnt <= '0;
         end else if ((state == S_FLUSH) && (cnt != END_SLOT)) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt;
            wr_data_q <= shadow[cnt];
            cnt       <= cnt + 5'd1;
         end
`endif
      end
   end

`ifdef PARAM_FRAME_LOADER_SHADOW_EN
   // Shadow capture of parameter bytes; contents are don't-care until loaded.
   always_ff @(posedge clk) begin
      if ((state == S_LOAD) && accept) begin
         shadow[cnt] <= bus.data_in;
      end
   end
`endif

   assign bus.data_ready   = ready;
   assign bus.busy         = busy_c;
   assign bus.done         = (state == S_DONE);
   assign bus.checksum_err = (state == S_ERR);
   assign bus.wr_en        = wr_en_q;
   assign bus.wr_addr      = wr_addr_q;
   assign bus.wr_data      = wr_data_q;
   assign bus.dbg_state    = state;

endmodule

// File: tb/tb_param_frame_loader.sv
// Directed bench for param_frame_loader: good frame, bad checksum, header
// resync, stalled stream, mid-frame reset and (shadow build) flush behaviour.
module tb_param_frame_loader;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_HDR  = 3'd1;
   localparam logic [2:0] ST_LOAD = 3'd2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   param_frame_loader_if #(.DATA_W(8)) bus ();

   param_frame_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int wr_cnt = 0;
   int first_wr_cyc = 0;
   int last_wr_cyc  = 0;
   logic [12:0] exp_q[$];

   // Cycle counter for write contiguity checks.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write scoreboard: every strobe must match the next expected {addr,data}.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (wr_cnt == 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         wr_cnt++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL wr_unexpected: observed addr %0d data %0h expected no write",
                   bus.wr_addr, bus.wr_data);
         end else begin
            check("wr_addr_data", {19'd0, bus.wr_addr, bus.wr_data}, {19'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      int tries;
      bus.data_valid = 1'b0;
      if (gap > 0) step(gap);
      bus.data_in    = b;
      bus.data_valid = 1'b1;
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         acc = bus.data_ready;
         step(1);
         tries++;
      end
      bus.data_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $error("FAIL send_timeout: observed data_ready 0 expected byte %0h accepted", b);
      end
   endtask

   // Parameter bytes 0x01.. with optional random stall gaps.
   task automatic send_params(input int n, input int gmin, input int gmax);
      int gap;
      for (int i = 0; i < n; i++) begin
         gap = (gmax == 0) ? 0 : int'($urandom_range(gmin, gmax));
`ifndef PARAM_FRAME_LOADER_SHADOW_EN
         exp_q.push_back({5'(i), 8'(i + 1)});
`endif
         send_byte(8'(i + 1), gap);
      end
   endtask

`ifdef PARAM_FRAME_LOADER_SHADOW_EN
   // Flush after a good checksum: 24 back-to-back writes, done one cycle later.
   task automatic flush_and_check(input bit poke_start);
      int n;
      check("flush_busy", bus.busy, 1);
      check("flush_no_wr_yet", bus.wr_en, 0);
      check("flush_not_done", bus.done, 0);
      for (int i = 0; i < 24; i++) exp_q.push_back({5'(i), 8'(i + 1)});
      n = 0;
      while (!(bus.wr_en === 1'b1 && bus.wr_addr == 5'd23) && n < 40) begin
         if (poke_start && n == 5) bus.start = 1'b1;
         step(1);
         bus.start = 1'b0;
         n++;
      end
      check("flush_last_wr_seen", (n < 40), 1);
      check("flush_ready_low", bus.data_ready, 0);
      check("done_not_yet", bus.done, 0);
      step(1);
      check("flush_contiguous", last_wr_cyc - first_wr_cyc, 23);
   endtask
`endif

   task automatic expect_good(input bit poke_start);
`ifdef PARAM_FRAME_LOADER_SHADOW_EN
      flush_and_check(poke_start);
`endif
      check("good_done", bus.done, 1);
      check("good_err", bus.checksum_err, 0);
      check("good_busy", bus.busy, 0);
      check("good_ready", bus.data_ready, 0);
      check("good_exp_empty", exp_q.size(), 0);
      check("good_wr_cnt", wr_cnt, 24);
   endtask

   initial begin
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.data_in    = '0;
      bus.data_valid = 1'b0;
      step(2);

      // Reset state.
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.checksum_err, 0);
      check("rst_ready", bus.data_ready, 0);
      check("rst_state", bus.dbg_state, ST_IDLE);
      reset = 1'b0;
      step(1);

      // Test 1: good frame; start with data_valid in IDLE does not consume.
      wr_cnt         = 0;
      bus.data_in    = 8'hA5;
      bus.data_valid = 1'b1;
      pulse_start();
      bus.data_valid = 1'b0;
      check("t1_state_hdr", bus.dbg_state, ST_HDR);
      check("t1_busy", bus.busy, 1);
      check("t1_ready", bus.data_ready, 1);
      send_byte(8'hA5, 0);
      check("t1_state_load", bus.dbg_state, ST_LOAD);
      send_params(24, 0, 0);
      send_byte(8'hD4, 0);
      expect_good(1'b1);

      // Test 2: bad checksum byte.
      wr_cnt = 0;
      pulse_start();
      check("t2_done_cleared", bus.done, 0);
      send_byte(8'hA5, 0);
      send_params(24, 0, 0);
      send_byte(8'h00, 0);
      step(3);
      check("t2_err", bus.checksum_err, 1);
      check("t2_done", bus.done, 0);
      check("t2_ready", bus.data_ready, 0);
      check("t2_busy", bus.busy, 0);
      check("t2_exp_empty", exp_q.size(), 0);
`ifdef PARAM_FRAME_LOADER_SHADOW_EN
      check("t2_wr_cnt", wr_cnt, 0);
`else
      check("t2_wr_cnt", wr_cnt, 24);
`endif

      // Test 3: resync on junk before the header.
      wr_cnt = 0;
      pulse_start();
      check("t3_err_cleared", bus.checksum_err, 0);
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 0);
      check("t3_still_hdr", bus.dbg_state, ST_HDR);
      check("t3_no_wr", wr_cnt, 0);
      send_byte(8'hA5, 0);
      send_params(24, 0, 0);
      send_byte(8'hD4, 0);
      expect_good(1'b0);

      // Test 4: stalls of 1..3 cycles between bytes.
      wr_cnt = 0;
      pulse_start();
      send_byte(8'hA5, 2);
      send_params(24, 1, 3);
      send_byte(8'hD4, 3);
      expect_good(1'b0);

      // Test 5: reset after the 10th parameter byte.
      wr_cnt = 0;
      pulse_start();
      send_byte(8'hA5, 0);
      send_params(10, 0, 0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t5_wr_en", bus.wr_en, 0);
      check("t5_wr_addr", bus.wr_addr, 0);
      check("t5_wr_data", bus.wr_data, 0);
      check("t5_busy", bus.busy, 0);
      check("t5_done", bus.done, 0);
      check("t5_err", bus.checksum_err, 0);
      check("t5_ready", bus.data_ready, 0);
      bus.data_valid = 1'b1;
      for (int k = 0; k < 14; k++) begin
         bus.data_in = 8'(k + 11);
         step(1);
         check("t5_no_wr_idle", bus.wr_en, 0);
      end
      bus.data_valid = 1'b0;
      check("t5_exp_empty", exp_q.size(), 0);
`ifdef PARAM_FRAME_LOADER_SHADOW_EN
      check("t5_wr_cnt", wr_cnt, 0);
`else
      check("t5_wr_cnt", wr_cnt, 10);
`endif
      wr_cnt = 0;
      pulse_start();
      send_byte(8'hA5, 0);
      send_params(24, 0, 0);
      send_byte(8'hD4, 0);
      expect_good(1'b0);

`ifdef PARAM_FRAME_LOADER_SHADOW_EN
      // Test 6: reset during flush aborts the remaining writes.
      wr_cnt = 0;
      pulse_start();
      send_byte(8'hA5, 0);
      send_params(24, 0, 0);
      send_byte(8'hD4, 0);
      for (int i = 0; i < 24; i++) exp_q.push_back({5'(i), 8'(i + 1)});
      step(5);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("t6_wr_en", bus.wr_en, 0);
      check("t6_busy", bus.busy, 0);
      check("t6_done", bus.done, 0);
      check("t6_wr_cnt", wr_cnt, 5);
      check("t6_exp_left", exp_q.size(), 19);
      exp_q.delete();
      step(30);
      check("t6_no_more_wr", wr_cnt, 5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
